// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between several writeback
// sources (main pipeline WB, mul/div unit, out-of-order load return).
// At most one request with a nonzero destination is granted per cycle. The
// granted write is registered and presented to the register file on the
// following cycle.
//
// Handshake: requester i transfers in a cycle where req_valid_in[i] and
// req_ready_out[i] are both 1. Until then the requester holds valid, addr
// and data stable. req_ready_out is combinational from the request inputs
// and the wait-counter state only.
//
// Requests to x0 (addr 0) are accepted at once. They never take the port
// and never produce a write.
//
// Optional feature macro: WB_ARB_STARVE_GUARD_EN
//   defined   : a per-requester 4-bit wait counter is built. A requester
//               blocked STARVE_LIMIT consecutive cycles is granted next,
//               ahead of every non-starved requester.
//   undefined : strict fixed priority (index 0 highest). STARVE_LIMIT is
//               ignored.
//
// Parameters:
//   NREQ         number of requesters (2..8), index 0 highest priority
//   STARVE_LIMIT blocked cycles before a forced grant (1..15)
//   GW           width of the grant index
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   req_valid_in        request valid, one bit per requester
//   req_addr_in         destination register, 5 bits per requester
//   req_data_in         write data, 32 bits per requester
//   req_ready_out       request accepted this cycle (combinational)
//   wb_write_addr_out   registered write address
//   wb_write_data_out   registered write data
//   wb_reg_write_en_out registered write enable
//   wb_grant_id_out     index of the requester whose write is on the port
//   busy_out            some valid nonzero-address request is blocked
//                       this cycle (combinational)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int NREQ         = 3,
    parameter int STARVE_LIMIT = 4,
    parameter int GW           = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid_in,
    input  logic [NREQ*5-1:0]  req_addr_in,
    input  logic [NREQ*32-1:0] req_data_in,
    output logic [NREQ-1:0]    req_ready_out,
    output logic [4:0]         wb_write_addr_out,
    output logic [31:0]        wb_write_data_out,
    output logic               wb_reg_write_en_out,
    output logic [GW-1:0]      wb_grant_id_out,
    output logic               busy_out
);

    // Requests that compete for the port (valid, nonzero destination).
    logic [NREQ-1:0] contend;
    // Requests to x0, accepted without using the port.
    logic [NREQ-1:0] x0_req;
    // Competing requesters whose wait counter reached the limit.
    logic [NREQ-1:0] starved;

    logic [NREQ-1:0] grant_vec;
    logic            grant_any;
    logic [GW-1:0]   grant_idx;
    logic [4:0]      grant_addr;
    logic [31:0]     grant_data;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    always_comb begin
        contend = '0;
        x0_req  = '0;
        for (int i = 0; i < NREQ; i++) begin
            contend[i] = req_valid_in[i] && (req_addr_in[5*i +: 5] != 5'd0);
            x0_req[i]  = req_valid_in[i] && (req_addr_in[5*i +: 5] == 5'd0);
        end
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    // -----------------------------------------------------------------------
    // Starvation guard: count consecutive blocked cycles per requester
    // -----------------------------------------------------------------------
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt [NREQ];

    always_comb begin
        starved = '0;
        for (int i = 0; i < NREQ; i++) begin
            starved[i] = contend[i] && (wait_cnt[i] == LIMIT);
        end
    end

    // Counter counts only while the request is pending and blocked. It
    // clears on acceptance, when the request drops, and for x0 requests,
    // which are always accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                wait_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (contend[i] && !grant_vec[i]) begin
                    if (wait_cnt[i] != LIMIT) begin
                        wait_cnt[i] <= wait_cnt[i] + 4'd1;
                    end
                end else begin
                    wait_cnt[i] <= 4'd0;
                end
            end
        end
    end
`else
    // Strict fixed priority: no requester is ever treated as starved.
    assign starved = '0;

    // STARVE_LIMIT has no effect in this build; tie it off explicitly.
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

    // -----------------------------------------------------------------------
    // Arbitration: lowest-index starved requester first, otherwise the
    // lowest-index competing requester. Starved is a subset of contend, so
    // a grant always goes to a valid nonzero-address request.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_vec  = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_addr = 5'd0;
        grant_data = 32'd0;
        if (|starved) begin
            for (int i = 0; i < NREQ; i++) begin
                if (starved[i] && !grant_any) begin
                    grant_any    = 1'b1;
                    grant_vec[i] = 1'b1;
                    grant_idx    = GW'(i);
                    grant_addr   = req_addr_in[5*i +: 5];
                    grant_data   = req_data_in[32*i +: 32];
                end
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (contend[i] && !grant_any) begin
                    grant_any    = 1'b1;
                    grant_vec[i] = 1'b1;
                    grant_idx    = GW'(i);
                    grant_addr   = req_addr_in[5*i +: 5];
                    grant_data   = req_data_in[32*i +: 32];
                end
            end
        end
    end

    assign req_ready_out = x0_req | grant_vec;
    assign busy_out      = |(contend & ~grant_vec);

    // -----------------------------------------------------------------------
    // Output register: load on a grant, otherwise drop enable and hold the
    // last address, data and id.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_write_addr_out   <= 5'd0;
            wb_write_data_out   <= 32'd0;
            wb_reg_write_en_out <= 1'b0;
            wb_grant_id_out     <= '0;
        end else begin
            wb_reg_write_en_out <= grant_any;
            if (grant_any) begin
                wb_write_addr_out <= grant_addr;
                wb_write_data_out <= grant_data;
                wb_grant_id_out   <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed, table-driven bench for wb_port_arbiter with NREQ=3 and
// STARVE_LIMIT=4. Table vectors are applied one per cycle. Ready and busy
// are checked at the falling edge, and the registered port one cycle later.
// Hand-written sequences cover back-to-back grants, starvation (with or
// without WB_ARB_STARVE_GUARD_EN) and asynchronous reset mid-operation.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int NREQ = 3;
    localparam int GW   = 2;

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [2:0]      req_valid_in;
    logic [14:0]     req_addr_in;
    logic [95:0]     req_data_in;
    logic [2:0]      req_ready_out;
    logic [4:0]      wb_write_addr_out;
    logic [31:0]     wb_write_data_out;
    logic            wb_reg_write_en_out;
    logic [GW-1:0]   wb_grant_id_out;
    logic            busy_out;

    int checks = 0;
    int passes = 0;

    wb_port_arbiter #(
        .NREQ(NREQ),
        .STARVE_LIMIT(4),
        .GW(GW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_in(req_valid_in),
        .req_addr_in(req_addr_in),
        .req_data_in(req_data_in),
        .req_ready_out(req_ready_out),
        .wb_write_addr_out(wb_write_addr_out),
        .wb_write_data_out(wb_write_data_out),
        .wb_reg_write_en_out(wb_reg_write_en_out),
        .wb_grant_id_out(wb_grant_id_out),
        .busy_out(busy_out)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_port(input string tag, input logic en, input logic [4:0] addr,
                              input logic [31:0] data, input logic [1:0] id);
        check({tag, " en"},   64'(wb_reg_write_en_out), 64'(en));
        check({tag, " addr"}, 64'(wb_write_addr_out),   64'(addr));
        check({tag, " data"}, 64'(wb_write_data_out),   64'(data));
        check({tag, " id"},   64'(wb_grant_id_out),     64'(id));
    endtask

    function automatic logic [14:0] pa(input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0);
        return {a2, a1, a0};
    endfunction

    function automatic logic [95:0] pd(input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0);
        return {d2, d1, d0};
    endfunction

    // ---------------- handshake assertion ----------------
    // A request pending (valid, not ready) at one falling edge must still be
    // valid with identical addr and data at the next one.
    logic [2:0]  prev_pend;
    logic [14:0] prev_addr;
    logic [95:0] prev_data;
    initial prev_pend = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_pend = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (prev_pend[i]) begin
                    check($sformatf("hold req%0d", i),
                          {31'd0, req_valid_in[i], req_addr_in[5*i +: 5], req_data_in[32*i +: 32]},
                          {31'd0, 1'b1, prev_addr[5*i +: 5], prev_data[32*i +: 32]});
                end
            end
            prev_pend = req_valid_in & ~req_ready_out;
            prev_addr = req_addr_in;
            prev_data = req_data_in;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        logic        exp_busy;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[12];

    logic [4:0]  a0;
    logic [2:0]  exp_rdy;
    int          ncyc;

    initial begin
        vecs[0]  = '{3'b000, pa(0, 0, 0),  pd(0, 0, 0),                   3'b000, 1'b0, 1'b0, 5'd0,  32'd0,         2'd0};
        vecs[1]  = '{3'b010, pa(0, 5, 0),  pd(0, 32'hDEADBEEF, 0),        3'b010, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF,  2'd1};
        vecs[2]  = '{3'b000, pa(0, 0, 0),  pd(0, 0, 0),                   3'b000, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF,  2'd1};
        vecs[3]  = '{3'b011, pa(0, 7, 0),  pd(0, 32'h77, 32'h99),         3'b011, 1'b0, 1'b1, 5'd7,  32'h77,        2'd1};
        vecs[4]  = '{3'b111, pa(6, 4, 3),  pd(32'h33, 32'h22, 32'h11),    3'b001, 1'b1, 1'b1, 5'd3,  32'h11,        2'd0};
        vecs[5]  = '{3'b110, pa(6, 4, 0),  pd(32'h33, 32'h22, 0),         3'b010, 1'b1, 1'b1, 5'd4,  32'h22,        2'd1};
        vecs[6]  = '{3'b100, pa(6, 0, 0),  pd(32'h33, 0, 0),              3'b100, 1'b0, 1'b1, 5'd6,  32'h33,        2'd2};
        vecs[7]  = '{3'b000, pa(0, 0, 0),  pd(0, 0, 0),                   3'b000, 1'b0, 1'b0, 5'd6,  32'h33,        2'd2};
        vecs[8]  = '{3'b001, pa(0, 0, 0),  pd(0, 0, 32'h55),              3'b001, 1'b0, 1'b0, 5'd6,  32'h33,        2'd2};
        vecs[9]  = '{3'b111, pa(0, 0, 9),  pd(32'hBB, 32'hCC, 32'hAA),    3'b111, 1'b0, 1'b1, 5'd9,  32'hAA,        2'd0};
        vecs[10] = '{3'b100, pa(31, 0, 0), pd(32'hFFFFFFFF, 0, 0),        3'b100, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF,  2'd2};
        vecs[11] = '{3'b000, pa(0, 0, 0),  pd(0, 0, 0),                   3'b000, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF,  2'd2};

        // ---------------- reset ----------------
        rst          = 1'b1;
        req_valid_in = '0;
        req_addr_in  = '0;
        req_data_in  = '0;
        #2 rst = 1'b0;
        #1 check_port("reset", 1'b0, 5'd0, 32'd0, 2'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- table vectors ----------------
        for (int v = 0; v < 12; v++) begin
            req_valid_in = vecs[v].valid;
            req_addr_in  = vecs[v].addr;
            req_data_in  = vecs[v].data;
            @(negedge clk);
            check($sformatf("v%0d ready", v), 64'(req_ready_out), 64'(vecs[v].exp_ready));
            check($sformatf("v%0d busy", v),  64'(busy_out),      64'(vecs[v].exp_busy));
            @(posedge clk);
            #1;
            check_port($sformatf("v%0d port", v), vecs[v].exp_en, vecs[v].exp_addr,
                       vecs[v].exp_data, vecs[v].exp_id);
        end

        // ---------------- back-to-back grants ----------------
        req_valid_in = 3'b111;
        req_addr_in  = pa(6, 4, 3);
        req_data_in  = pd(32'h33, 32'h22, 32'h11);
        @(negedge clk);
        check("b2b c0 ready", 64'(req_ready_out), 64'(3'b001));
        @(posedge clk); #1;
        check_port("b2b c0", 1'b1, 5'd3, 32'h11, 2'd0);
        req_valid_in = 3'b110;
        @(negedge clk);
        check("b2b c1 ready", 64'(req_ready_out), 64'(3'b010));
        @(posedge clk); #1;
        check_port("b2b c1", 1'b1, 5'd4, 32'h22, 2'd1);
        req_valid_in = 3'b100;
        @(negedge clk);
        check("b2b c2 ready", 64'(req_ready_out), 64'(3'b100));
        @(posedge clk); #1;
        check_port("b2b c2", 1'b1, 5'd6, 32'h33, 2'd2);
        req_valid_in = 3'b000;
        @(posedge clk); #1;
        check_port("b2b idle", 1'b0, 5'd6, 32'h33, 2'd2);

        // ---------------- starvation ----------------
        a0           = 5'd1;
        req_valid_in = 3'b101;
        req_addr_in  = pa(10, 0, a0);
        req_data_in  = pd(32'hCAFE, 0, 32'h1000 + 32'(a0));
        ncyc         = GUARD ? 8 : 20;
        for (int c = 0; c < ncyc; c++) begin
            exp_rdy = (GUARD && c == 4) ? 3'b100 : 3'b001;
            @(negedge clk);
            check($sformatf("starve c%0d ready", c), 64'(req_ready_out), 64'(exp_rdy));
            @(posedge clk); #1;
            if (exp_rdy == 3'b100) begin
                check_port($sformatf("starve c%0d", c), 1'b1, 5'd10, 32'hCAFE, 2'd2);
                req_valid_in[2] = 1'b0;
            end else begin
                check_port($sformatf("starve c%0d", c), 1'b1, a0, 32'h1000 + 32'(a0), 2'd0);
                a0 = 5'((int'(a0) % 31) + 1);
            end
            req_addr_in = pa(10, 0, a0);
            req_data_in = pd(32'hCAFE, 0, 32'h1000 + 32'(a0));
        end

        // ---------------- reset mid-operation ----------------
        req_valid_in = 3'b111;
        req_addr_in  = pa(10, 13, 12);
        req_data_in  = pd(32'hCAFE, 32'h1300, 32'h1200);
        @(negedge clk);
        check("rst pre ready", 64'(req_ready_out), 64'(3'b001));
        @(posedge clk); #1;
        check_port("rst pre", 1'b1, 5'd12, 32'h1200, 2'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_port("rst async", 1'b0, 5'd0, 32'd0, 2'd0);
        @(posedge clk); #1;
        check_port("rst held", 1'b0, 5'd0, 32'd0, 2'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst post ready", 64'(req_ready_out), 64'(3'b001));
        check("rst post busy",  64'(busy_out),      64'(1'b1));
        @(posedge clk); #1;
        check_port("rst first", 1'b1, 5'd12, 32'h1200, 2'd0);
        req_valid_in = 3'b110;
        @(negedge clk);
        check("rst next ready", 64'(req_ready_out), 64'(3'b010));
        @(posedge clk); #1;
        check_port("rst next", 1'b1, 5'd13, 32'h1300, 2'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
